// File: rtl/bs_pkg.sv
// Shared definitions for the bit-serial MAC operand path: precision codes,
// bit-counter width, operand pair layout and feeder state encoding.
package bs_pkg;

  localparam logic [1:0] PREC_8 = 2'b00;
  localparam logic [1:0] PREC_4 = 2'b01;
  localparam logic [1:0] PREC_2 = 2'b10;

  localparam int CNT_W   = 3;
  localparam int PAIR_DW = 8;

  typedef struct packed {
    logic [PAIR_DW-1:0] act;
    logic [PAIR_DW-1:0] wgt;
    logic               last;
  } pair_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True on the final bit-cycle of a pair; code 11 behaves like 8-bit.
  function automatic logic at_boundary(input logic [1:0] p, input logic [CNT_W-1:0] ph);
    logic hit;
    case (p)
      PREC_4:  hit = (ph[1:0] == 2'b11);
      PREC_2:  hit = ph[0];
      default: hit = (ph == 3'b111);
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/bs_operand_feeder_if.sv
// Producer-side handshake and MAC-side operand bus of the operand feeder.
// master = pair producer / MAC observer, slave = the feeder itself.
interface bs_operand_feeder_if
  import bs_pkg::*;
#(
  parameter int DW = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_act;
  logic [DW-1:0]    in_wgt;
  logic             in_last;
  logic [DW-1:0]    mac_act;
  logic [DW-1:0]    mac_wgt;
  logic             mac_en;
  logic [CNT_W-1:0] phase;

  modport master (
    output in_valid, in_act, in_wgt, in_last,
    input  in_ready, mac_act, mac_wgt, mac_en, phase
  );

  modport slave (
    input  in_valid, in_act, in_wgt, in_last,
    output in_ready, mac_act, mac_wgt, mac_en, phase
  );

endinterface

// File: rtl/bs_sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset; head entry is
// visible on rdata whenever the FIFO is non-empty.
module bs_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bs_operand_feeder.sv
// Operand feeder for the bit-serial MAC: queues act/wgt pairs and holds each
// one for 8/4/2 enabled cycles so the MAC bit counter stays pair-aligned.
module bs_operand_feeder
  import bs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          prec,
  bs_operand_feeder_if.slave  bus,
  output logic                busy,
  output logic                vec_done
);

  localparam int PW = 2 * DW + 1;
  localparam int CW = $clog2(DEPTH) + 1;

  state_t          state;
  state_t          state_nx;
  logic [PW-1:0]   head;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nx;
  logic            push;
  logic            pop;
  logic            start_vec;
  logic            en_nx;
  logic            done_nx;
  logic            at_edge;
  logic            last_q;
  logic            in_vec;
  logic [1:0]      prec_q;

  assign bus.in_ready = !full && !rst;
  assign push         = bus.in_valid && bus.in_ready;
  assign at_edge      = at_boundary(prec_q, bus.phase);

  bs_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({bus.in_act, bus.in_wgt, bus.in_last}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (!empty) state_nx = RUN;
      RUN: begin
        if (at_edge) begin
          if (last_q)     state_nx = DONE;
          else if (empty) state_nx = IDLE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A pair boundary pops the next entry in the same edge, so back-to-back
  // pairs keep mac_en high without a bubble.
  always_comb begin
    pop       = 1'b0;
    start_vec = 1'b0;
    en_nx     = 1'b0;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          en_nx     = 1'b1;
          start_vec = !in_vec;
        end
      end
      RUN: begin
        en_nx = 1'b1;
        if (at_edge) begin
          if (last_q) begin
            en_nx   = 1'b0;
            done_nx = 1'b1;
          end else if (!empty) begin
            pop = 1'b1;
          end else begin
            en_nx = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  assign count_nx = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mac_act <= '0;
      bus.mac_wgt <= '0;
      bus.mac_en  <= 1'b0;
      bus.phase   <= '0;
      last_q      <= 1'b0;
      prec_q      <= PREC_8;
      in_vec      <= 1'b0;
      busy        <= 1'b0;
      vec_done    <= 1'b0;
    end else begin
      bus.mac_en <= en_nx;
      vec_done   <= done_nx;
      busy       <= en_nx || (count_nx != '0);
      if (bus.mac_en) bus.phase <= bus.phase + 1'b1;
      if (pop) {bus.mac_act, bus.mac_wgt, last_q} <= head;
      // Precision is frozen for the whole vector once its first pair starts.
      if (start_vec) begin
        prec_q <= (prec == 2'b11) ? PREC_8 : prec;
        in_vec <= 1'b1;
      end else if (done_nx) begin
        in_vec <= 1'b0;
      end
    end
  end

endmodule
